// File: rtl/fabric_config_loader_if.sv
// Byte-wide configuration stream carrying the framed bitstream into the loader.
// Signals: in_valid (byte present), in_data (byte), in_ready (loader accepts).
// master = bitstream source, slave = fabric_config_loader.
interface fabric_config_loader_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fabric_config_loader.sv
// Parses the framed configuration bitstream and drives one-hot tile write strobes.
// Ports: conf/reset, in_stream (valid/ready byte stream), select_tile/address_tile/data_tile
//   write bus (1-cycle registered latency), sticky done/error status.
// Back-pressure: in_ready is high in every state but S_DONE, and depends on state only.
module fabric_config_loader #(
  parameter int NB_TILES = 4,
  parameter int ADDR_W   = 10,  // 9..16: upper bits come from H1[ADDR_W-9:0]
  parameter int DATA_W   = 8    // header fields use bits [7:0]
) (
  input  logic                    conf,
  input  logic                    reset,
  fabric_config_loader_if.slave   in_stream,
  output logic [NB_TILES-1:0]     select_tile,
  output logic [ADDR_W-1:0]       address_tile,
  output logic [DATA_W-1:0]       data_tile,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [2:0] {
    S_TILE, S_AHI, S_ALO, S_CNT, S_DATA, S_SKIP, S_CHK, S_DONE
  } state_t;

  state_t              state;
  logic [7:0]          idx;       // tile index from H0
  logic                last;      // LAST flag from H1
  logic [ADDR_W-1:0]   addr;      // next write address inside the tile
  logic [7:0]          cnt;       // data bytes remaining minus one
  logic [DATA_W-1:0]   xor_acc;   // running checksum of H0..Dn
  logic                accept;
  logic [NB_TILES-1:0] sel_onehot;

  assign in_stream.in_ready = (state != S_DONE);
  assign accept             = in_stream.in_valid && in_stream.in_ready;

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NB_TILES; i++) begin
      sel_onehot[i] = (32'(idx) == i);
    end
  end

  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      state        <= S_TILE;
      idx          <= '0;
      last         <= 1'b0;
      addr         <= '0;
      cnt          <= '0;
      xor_acc      <= '0;
      select_tile  <= '0;
      address_tile <= '0;
      data_tile    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse; address/data hold between writes.
      select_tile <= '0;
      if (accept) begin
        // Checksum byte itself is never folded in; it clears the sum instead.
        if (state != S_CHK) xor_acc <= xor_acc ^ in_stream.in_data;
        case (state)
          S_TILE: begin
            idx   <= in_stream.in_data[7:0];
            state <= S_AHI;
          end
          S_AHI: begin
            last                <= in_stream.in_data[7];
            addr[ADDR_W-1:8]    <= in_stream.in_data[ADDR_W-9:0];
            state               <= S_ALO;
          end
          S_ALO: begin
            addr[7:0] <= in_stream.in_data[7:0];
            state     <= S_CNT;
          end
          S_CNT: begin
            cnt <= in_stream.in_data[7:0];
            if (32'(idx) < NB_TILES) begin
              state <= S_DATA;
            end else begin
              // Out-of-range tile: consume the payload without strobing.
              state <= S_SKIP;
              error <= 1'b1;
            end
          end
          S_DATA: begin
            select_tile  <= sel_onehot;
            address_tile <= addr;
            data_tile    <= in_stream.in_data;
            addr         <= addr + 1'b1;  // wraps silently at 2^ADDR_W
            if (cnt == 8'd0) state <= S_CHK;
            else             cnt   <= cnt - 1'b1;
          end
          S_SKIP: begin
            if (cnt == 8'd0) state <= S_CHK;
            else             cnt   <= cnt - 1'b1;
          end
          S_CHK: begin
            if (in_stream.in_data != xor_acc) error <= 1'b1;
            xor_acc <= '0;
            if (last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_TILE;
            end
          end
          default: state <= S_DONE;  // S_DONE never accepts
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
module tb_fabric_config_loader;

  logic       conf;
  logic       reset;
  logic [3:0] select_tile;
  logic [9:0] address_tile;
  logic [7:0] data_tile;
  logic       done;
  logic       error;

  int n_tests;
  int n_fail;

  fabric_config_loader_if #(.DATA_W(8)) bus ();

  fabric_config_loader #(.NB_TILES(4), .ADDR_W(10), .DATA_W(8)) dut (
    .conf         (conf),
    .reset        (reset),
    .in_stream    (bus),
    .select_tile  (select_tile),
    .address_tile (address_tile),
    .data_tile    (data_tile),
    .done         (done),
    .error        (error)
  );

  initial conf = 1'b0;
  always #5 conf = ~conf;

  // One record = one cycle: stimulus driven before the edge, outputs expected after it.
  typedef struct {
    int         grp;
    logic       vld;
    logic [7:0] din;
    logic [3:0] sel;
    logic [9:0] addr;
    logic [7:0] dout;
    logic       dn;
    logic       er;
    logic       rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int g, logic v, logic [7:0] d, logic [3:0] s, logic [9:0] a,
                              logic [7:0] o, logic dn, logic er, logic rd);
    vec_t t;
    t.grp = g; t.vld = v; t.din = d; t.sel = s; t.addr = a; t.dout = o;
    t.dn = dn; t.er = er; t.rd = rd;
    tbl.push_back(t);
  endfunction

  task automatic check(string name, logic [3:0] es, logic [9:0] ea, logic [7:0] ed,
                       logic edn, logic eer, logic erd);
    n_tests++;
    if (select_tile !== es || address_tile !== ea || data_tile !== ed ||
        done !== edn || error !== eer || bus.in_ready !== erd) begin
      n_fail++;
      $display("FAIL %s: got sel=%b addr=%h data=%h done=%b err=%b rdy=%b, expected sel=%b addr=%h data=%h done=%b err=%b rdy=%b",
               name, select_tile, address_tile, data_tile, done, error, bus.in_ready,
               es, ea, ed, edn, eer, erd);
    end
  endtask

  task automatic do_reset(string name);
    @(negedge conf);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    @(negedge conf);
    @(negedge conf);
    reset = 1'b0;
    #1 check(name, 4'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_group(int g);
    int k;
    k = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].grp == g) begin
        @(negedge conf);
        bus.in_valid = tbl[i].vld;
        bus.in_data  = tbl[i].din;
        @(posedge conf);
        #1 check($sformatf("g%0d_v%0d", g, k), tbl[i].sel, tbl[i].addr, tbl[i].dout,
                 tbl[i].dn, tbl[i].er, tbl[i].rd);
        k++;
      end
    end
    @(negedge conf);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Group 1: tile 1, addr 0x005, CNT=2, A1 B2 C3, CK=56, LAST.
    add(1, 1, 8'h01, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(1, 1, 8'h80, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(1, 1, 8'h05, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(1, 1, 8'h02, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(1, 1, 8'hA1, 4'b0010, 10'h005, 8'hA1, 0, 0, 1);
    add(1, 1, 8'hB2, 4'b0010, 10'h006, 8'hB2, 0, 0, 1);
    add(1, 1, 8'hC3, 4'b0010, 10'h007, 8'hC3, 0, 0, 1);
    add(1, 1, 8'h56, 4'b0000, 10'h007, 8'hC3, 1, 0, 0);
    add(1, 1, 8'h99, 4'b0000, 10'h007, 8'hC3, 1, 0, 0);
    add(1, 0, 8'h00, 4'b0000, 10'h007, 8'hC3, 1, 0, 0);

    // Group 2: same frame with a 2-cycle stall between B2 and C3.
    add(2, 1, 8'h01, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(2, 1, 8'h80, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(2, 1, 8'h05, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(2, 1, 8'h02, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(2, 1, 8'hA1, 4'b0010, 10'h005, 8'hA1, 0, 0, 1);
    add(2, 1, 8'hB2, 4'b0010, 10'h006, 8'hB2, 0, 0, 1);
    add(2, 0, 8'hEE, 4'b0000, 10'h006, 8'hB2, 0, 0, 1);
    add(2, 0, 8'hEE, 4'b0000, 10'h006, 8'hB2, 0, 0, 1);
    add(2, 1, 8'hC3, 4'b0010, 10'h007, 8'hC3, 0, 0, 1);
    add(2, 1, 8'h56, 4'b0000, 10'h007, 8'hC3, 1, 0, 0);

    // Group 3: bad tile 4 (CNT=1, CK=36), then tile 0 addr 0x010 data 5A CK=CA LAST.
    add(3, 1, 8'h04, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(3, 1, 8'h00, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(3, 1, 8'h00, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(3, 1, 8'h01, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h11, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h22, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h36, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h00, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h80, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h10, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h00, 4'b0000, 10'h000, 8'h00, 0, 1, 1);
    add(3, 1, 8'h5A, 4'b0001, 10'h010, 8'h5A, 0, 1, 1);
    add(3, 1, 8'hCA, 4'b0000, 10'h010, 8'h5A, 1, 1, 0);

    // Group 4: tile 3, addr 0x3FE, CNT=2, 10 20 30, wrong CK (00; correct is FC), LAST=0.
    add(4, 1, 8'h03, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(4, 1, 8'h03, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(4, 1, 8'hFE, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(4, 1, 8'h02, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(4, 1, 8'h10, 4'b1000, 10'h3FE, 8'h10, 0, 0, 1);
    add(4, 1, 8'h20, 4'b1000, 10'h3FF, 8'h20, 0, 0, 1);
    add(4, 1, 8'h30, 4'b1000, 10'h000, 8'h30, 0, 0, 1);
    add(4, 1, 8'h00, 4'b0000, 10'h000, 8'h30, 0, 1, 1);
    add(4, 0, 8'h00, 4'b0000, 10'h000, 8'h30, 0, 1, 1);

    // Group 5: start of tile 2 addr 0x020 CNT=3 frame, up to D0.
    add(5, 1, 8'h02, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(5, 1, 8'h00, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(5, 1, 8'h20, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(5, 1, 8'h03, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(5, 1, 8'h01, 4'b0100, 10'h020, 8'h01, 0, 0, 1);

    // Group 6: tile 0 addr 0x100 (11 22, CK=33) then tile 2 addr 0x040 (77, CK=B5, LAST).
    add(6, 1, 8'h00, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(6, 1, 8'h01, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(6, 1, 8'h00, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(6, 1, 8'h01, 4'b0000, 10'h000, 8'h00, 0, 0, 1);
    add(6, 1, 8'h11, 4'b0001, 10'h100, 8'h11, 0, 0, 1);
    add(6, 1, 8'h22, 4'b0001, 10'h101, 8'h22, 0, 0, 1);
    add(6, 1, 8'h33, 4'b0000, 10'h101, 8'h22, 0, 0, 1);
    add(6, 1, 8'h02, 4'b0000, 10'h101, 8'h22, 0, 0, 1);
    add(6, 1, 8'h80, 4'b0000, 10'h101, 8'h22, 0, 0, 1);
    add(6, 1, 8'h40, 4'b0000, 10'h101, 8'h22, 0, 0, 1);
    add(6, 1, 8'h00, 4'b0000, 10'h101, 8'h22, 0, 0, 1);
    add(6, 1, 8'h77, 4'b0100, 10'h040, 8'h77, 0, 0, 1);
    add(6, 1, 8'hB5, 4'b0000, 10'h040, 8'h77, 1, 0, 0);

    do_reset("reset_1");
    run_group(1);
    do_reset("reset_2");
    run_group(2);
    do_reset("reset_3");
    run_group(3);
    do_reset("reset_4");
    run_group(4);
    do_reset("reset_5");
    run_group(5);

    // Reset mid-frame while D1 is being presented: outputs must clear before any edge.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    #2 reset = 1'b1;
    #1 check("rst_async", 4'b0000, 10'h000, 8'h00, 1'b0, 1'b0, 1'b1);
    @(posedge conf);
    #1 check("rst_no_strobe", 4'b0000, 10'h000, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge conf);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    run_group(1);

    do_reset("reset_6");
    run_group(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
